// File: rtl/i2c_sensor_responder.sv
// I2C target emulating a camera sensor's 16-bit-address / 8-bit-data register map (ID bytes + writable bank).
// Define I2C_GLITCH_FILTER_EN to insert a 3-sample majority filter after the scl/sda synchronisers.
module i2c_sensor_responder #(
    parameter logic [6:0]  DEV_ADDR  = 7'h10,
    parameter logic [15:0] CHIP_ID   = 16'h0219,
    parameter logic [15:0] REG_BASE  = 16'h0100,
    parameter int          REG_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        scl,
    inout  wire         sda,
    output logic        busy,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [7:0]  nack_cnt
);
    localparam int IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, ADDR_H, ACK_AH, ADDR_L, ACK_AL,
        WDATA, ACK_W, RDATA, RACK, WAIT_STOP
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  bit_cnt, bit_cnt_nx;
    logic [7:0]  shreg, shreg_nx;
    logic [7:0]  tx, tx_nx;
    logic [15:0] ptr, ptr_nx;
    logic        drive_low, drive_nx;
    logic        wr_en_nx;
    logic [15:0] wr_addr_nx;
    logic [7:0]  wr_data_nx;
    logic [7:0]  nack_nx;
    logic        bank_we;
    logic [7:0]  rd_val;
    logic [7:0]  rx_byte;
    logic [7:0]  bank [REG_DEPTH];

    logic scl_p0, scl_p1, sda_p0, sda_p1;
    logic scl_c, sda_c;
    logic scl_p2, sda_p2;
    logic scl_rise, scl_fall, start_det, stop_det;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic in_bank(input logic [15:0] a);
        return (a >= REG_BASE) && ((a - REG_BASE) < 16'(REG_DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] bank_idx(input logic [15:0] a);
        return IDX_W'(a - REG_BASE);
    endfunction

    // Stage p0/p1: two-flop synchronisers; idle bus level is high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
        end else begin
            scl_p0 <= scl;
            scl_p1 <= scl_p0;
            sda_p0 <= sda;
            sda_p1 <= sda_p0;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_h, sda_h;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_h <= 2'b11;
            sda_h <= 2'b11;
            scl_c <= 1'b1;
            sda_c <= 1'b1;
        end else begin
            scl_h <= {scl_h[0], scl_p1};
            sda_h <= {sda_h[0], sda_p1};
            scl_c <= maj3(scl_h[1], scl_h[0], scl_p1);
            sda_c <= maj3(sda_h[1], sda_h[0], sda_p1);
        end
    end
`else
    assign scl_c = scl_p1;
    assign sda_c = sda_p1;
`endif

    // Stage p2: previous clean levels for edge and START/STOP detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_p2 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p2 <= scl_c;
            sda_p2 <= sda_c;
        end
    end

    assign scl_rise  = scl_c & ~scl_p2;
    assign scl_fall  = ~scl_c & scl_p2;
    assign start_det = scl_c & scl_p2 & sda_p2 & ~sda_c;
    assign stop_det  = scl_c & scl_p2 & ~sda_p2 & sda_c;
    assign rx_byte   = {shreg[6:0], sda_c};

    always_comb begin
        rd_val = 8'h00;
        if (ptr == 16'h0000)
            rd_val = CHIP_ID[15:8];
        else if (ptr == 16'h0001)
            rd_val = CHIP_ID[7:0];
        else if (in_bank(ptr))
            rd_val = bank[bank_idx(ptr)];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // ACK states use drive_low as the phase flag: first SCL fall drives the ACK, second one releases it.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        tx_nx      = tx;
        ptr_nx     = ptr;
        drive_nx   = drive_low;
        wr_en_nx   = 1'b0;
        wr_addr_nx = wr_addr;
        wr_data_nx = wr_data;
        nack_nx    = nack_cnt;
        bank_we    = 1'b0;
        if (stop_det) begin
            state_nx = IDLE;
            drive_nx = 1'b0;
        end else if (start_det) begin
            state_nx   = DEV;
            bit_cnt_nx = 3'd0;
            drive_nx   = 1'b0;
        end else begin
            case (state)
                DEV, ADDR_H, ADDR_L, WDATA: begin
                    if (scl_rise) begin
                        shreg_nx   = rx_byte;
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            case (state)
                                DEV: begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state_nx = ACK_DEV;
                                    end else begin
                                        state_nx = WAIT_STOP;
                                        nack_nx  = sat_inc(nack_cnt);
                                    end
                                end
                                ADDR_H:  state_nx = ACK_AH;
                                ADDR_L:  state_nx = ACK_AL;
                                default: state_nx = ACK_W;
                            endcase
                        end
                    end
                end
                ACK_DEV, ACK_AH, ACK_AL, ACK_W: begin
                    if (scl_fall) begin
                        if (!drive_low) begin
                            drive_nx = 1'b1;
                        end else begin
                            drive_nx   = 1'b0;
                            bit_cnt_nx = 3'd0;
                            case (state)
                                ACK_DEV: begin
                                    if (shreg[0]) begin
                                        state_nx = RDATA;
                                        drive_nx = ~rd_val[7];
                                        tx_nx    = {rd_val[6:0], 1'b0};
                                        ptr_nx   = ptr + 16'd1;
                                    end else begin
                                        state_nx = ADDR_H;
                                    end
                                end
                                ACK_AH: begin
                                    ptr_nx[15:8] = shreg;
                                    state_nx     = ADDR_L;
                                end
                                ACK_AL: begin
                                    ptr_nx[7:0] = shreg;
                                    state_nx    = WDATA;
                                end
                                default: begin
                                    wr_en_nx   = 1'b1;
                                    wr_addr_nx = ptr;
                                    wr_data_nx = shreg;
                                    bank_we    = 1'b1;
                                    ptr_nx     = ptr + 16'd1;
                                    state_nx   = WDATA;
                                end
                            endcase
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state_nx = RACK;
                    end else if (scl_fall) begin
                        drive_nx = ~tx[7];
                        tx_nx    = {tx[6:0], 1'b0};
                    end
                end
                RACK: begin
                    // bit_cnt marks whether the master's ACK bit has been sampled yet
                    if (scl_rise) begin
                        shreg_nx[0] = sda_c;
                        bit_cnt_nx  = 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            drive_nx = 1'b0;
                        end else if (!shreg[0]) begin
                            state_nx   = RDATA;
                            bit_cnt_nx = 3'd0;
                            drive_nx   = ~rd_val[7];
                            tx_nx      = {rd_val[6:0], 1'b0};
                            ptr_nx     = ptr + 16'd1;
                        end else begin
                            state_nx = WAIT_STOP;
                            drive_nx = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            tx        <= 8'h00;
            ptr       <= 16'h0000;
            drive_low <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= 16'h0000;
            wr_data   <= 8'h00;
            nack_cnt  <= 8'h00;
        end else begin
            bit_cnt   <= bit_cnt_nx;
            shreg     <= shreg_nx;
            tx        <= tx_nx;
            ptr       <= ptr_nx;
            drive_low <= drive_nx;
            wr_en     <= wr_en_nx;
            wr_addr   <= wr_addr_nx;
            wr_data   <= wr_data_nx;
            nack_cnt  <= nack_nx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < REG_DEPTH; i++)
                bank[i] <= 8'h00;
        end else if (bank_we && in_bank(ptr)) begin
            bank[bank_idx(ptr)] <= shreg;
        end
    end

    assign busy = (state != IDLE);
    assign sda  = drive_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_sensor_responder.sv
// Bench for i2c_sensor_responder: bit-banged I2C master plus a register-map model of the sensor.
`timescale 1ns/1ps
module tb_i2c_sensor_responder;
    localparam int          Q        = 8;
    localparam logic [15:0] REG_BASE = 16'h0100;
    localparam int          DEPTH    = 16;
    localparam logic [7:0]  ID_H     = 8'h02;
    localparam logic [7:0]  ID_L     = 8'h19;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        scl  = 1'b1;
    logic        msda = 1'b1;
    wire         sda_bus;
    logic        busy;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  nack_cnt;

    assign sda_bus = msda ? 1'bz : 1'b0;
    pullup (sda_bus);

    i2c_sensor_responder dut (
        .clk(clk), .rstn(rstn), .scl(scl), .sda(sda_bus), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .nack_cnt(nack_cnt)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          low_cnt  = 0;
    logic [15:0] wq_addr [$];
    logic [7:0]  wq_data [$];
    logic [7:0]  bank_m [DEPTH];
    logic [15:0] ptr_m;
    logic [7:0]  nack_m;
    logic [7:0]  dbuf [8];

    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
        if (msda && sda_bus === 1'b0)
            low_cnt++;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a);
        int off = int'(a) - int'(REG_BASE);
        if (a == 16'h0000) return ID_H;
        if (a == 16'h0001) return ID_L;
        if (off >= 0 && off < DEPTH) return bank_m[off];
        return 8'h00;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        int off = int'(a) - int'(REG_BASE);
        if (off >= 0 && off < DEPTH) bank_m[off] = d;
    endtask

    task automatic tick_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        if (scl == 1'b0) begin
            msda = 1'b1; tick_q();
            scl  = 1'b1; tick_q();
        end
        msda = 1'b0; tick_q();
        scl  = 1'b0; tick_q();
    endtask

    task automatic i2c_stop();
        msda = 1'b0; tick_q();
        scl  = 1'b1; tick_q();
        msda = 1'b1; tick_q();
    endtask

    task automatic put_bit(input logic b);
        msda = b; tick_q();
        scl = 1'b1; tick_q(); tick_q();
        scl = 1'b0; tick_q();
    endtask

    task automatic get_bit(output logic b);
        msda = 1'b1; tick_q();
        scl = 1'b1; tick_q();
        b = sda_bus; tick_q();
        scl = 1'b0; tick_q();
    endtask

    task automatic put_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] v, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(mack);
    endtask

    task automatic do_write(input logic [15:0] a, input int n);
        logic ack;
        logic [15:0] wa;
        wq_addr.delete();
        wq_data.delete();
        i2c_start();
        check("wr_busy_on", 16'(busy), 16'h1);
        put_byte(8'h20, ack);    check("wr_dev_ack", 16'(ack), 16'h0);
        put_byte(a[15:8], ack);  check("wr_ah_ack", 16'(ack), 16'h0);
        put_byte(a[7:0], ack);   check("wr_al_ack", 16'(ack), 16'h0);
        for (int i = 0; i < n; i++) begin
            put_byte(dbuf[i], ack);
            check("wr_data_ack", 16'(ack), 16'h0);
        end
        i2c_stop();
        check("wr_busy_off", 16'(busy), 16'h0);
        check("wr_strobe_count", 16'(wq_addr.size()), 16'(n));
        wa = a;
        for (int i = 0; i < n; i++) begin
            if (wq_addr.size() > 0) begin
                check("wr_strobe_addr", wq_addr.pop_front(), wa);
                check("wr_strobe_data", 16'(wq_data.pop_front()), 16'(dbuf[i]));
            end
            model_write(wa, dbuf[i]);
            wa = wa + 16'd1;
        end
        ptr_m = wa;
    endtask

    task automatic do_read(input logic [15:0] a, input int n, input bit set_addr);
        logic ack;
        logic [7:0] v;
        logic [15:0] ra;
        i2c_start();
        check("rd_busy_on", 16'(busy), 16'h1);
        if (set_addr) begin
            put_byte(8'h20, ack);   check("rd_wdev_ack", 16'(ack), 16'h0);
            put_byte(a[15:8], ack); check("rd_ah_ack", 16'(ack), 16'h0);
            put_byte(a[7:0], ack);  check("rd_al_ack", 16'(ack), 16'h0);
            i2c_start();
            ra = a;
        end else begin
            ra = ptr_m;
        end
        put_byte(8'h21, ack);
        check("rd_dev_ack", 16'(ack), 16'h0);
        for (int i = 0; i < n; i++) begin
            get_byte(v, (i == n - 1));
            check("rd_data", 16'(v), 16'(model_read(ra)));
            ra = ra + 16'd1;
        end
        i2c_stop();
        check("rd_busy_off", 16'(busy), 16'h0);
        ptr_m = ra;
    endtask

    initial begin
        logic ack;
        logic [15:0] a;
        int base_low;
        int sel;
        for (int i = 0; i < DEPTH; i++) bank_m[i] = 8'h00;
        ptr_m  = 16'h0000;
        nack_m = 8'h00;

        repeat (4) @(posedge clk);
        #1;
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_wr_en", 16'(wr_en), 16'h0);
        check("rst_wr_addr", wr_addr, 16'h0000);
        check("rst_wr_data", 16'(wr_data), 16'h0);
        check("rst_nack_cnt", 16'(nack_cnt), 16'h0);
        check("rst_sda", 16'(sda_bus), 16'h1);
        rstn = 1'b1;
        tick_q();

        // Single write into the bank
        dbuf[0] = 8'hA5;
        do_write(16'h0100, 1);

        // Random read of the ID bytes, then a pointer-only read shows ptr moved to 0x0002
        do_read(16'h0000, 2, 1'b1);
        check("ptr_after_id_read", ptr_m, 16'h0002);
        do_read(16'h0000, 1, 1'b0);

        // Burst write across the top of the bank
        dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33;
        do_write(16'h010E, 3);
        do_read(16'h010E, 3, 1'b1);

        // Wrong device address
        base_low = low_cnt;
        wq_addr.delete();
        wq_data.delete();
        i2c_start();
        put_byte(8'h30, ack); check("bad_dev_nack", 16'(ack), 16'h1);
        put_byte(8'h01, ack); check("bad_follow_nack", 16'(ack), 16'h1);
        i2c_stop();
        nack_m = nack_m + 8'd1;
        check("bad_no_drive", 16'(low_cnt - base_low), 16'h0);
        check("bad_nack_cnt", 16'(nack_cnt), 16'(nack_m));
        check("bad_no_strobe", 16'(wq_addr.size()), 16'h0);
        dbuf[0] = 8'h3C;
        do_write(16'h0105, 1);

        // STOP after four data bits aborts the byte
        wq_addr.delete();
        wq_data.delete();
        i2c_start();
        put_byte(8'h20, ack); check("abort_dev_ack", 16'(ack), 16'h0);
        put_byte(8'h01, ack); check("abort_ah_ack", 16'(ack), 16'h0);
        put_byte(8'h03, ack); check("abort_al_ack", 16'(ack), 16'h0);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        i2c_stop();
        ptr_m = 16'h0103;
        check("abort_busy", 16'(busy), 16'h0);
        check("abort_sda", 16'(sda_bus), 16'h1);
        check("abort_no_strobe", 16'(wq_addr.size()), 16'h0);
        dbuf[0] = 8'h7E;
        do_write(16'h0103, 1);
        do_read(16'h0103, 1, 1'b1);

        // Pointer wrap 0xFFFF -> 0x0000
        dbuf[0] = 8'h99; dbuf[1] = 8'h66;
        do_write(16'hFFFF, 2);
        do_read(16'hFFFF, 3, 1'b1);

        // Randomised bursts checked against the model
        for (int it = 0; it < 6; it++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: a = REG_BASE - 16'd2 + 16'($urandom_range(0, DEPTH + 3));
                1: a = 16'($urandom_range(0, 3));
                2: a = 16'($urandom);
                default: a = REG_BASE + 16'($urandom_range(0, DEPTH - 1));
            endcase
            for (int i = 0; i < 8; i++) dbuf[i] = 8'($urandom);
            do_write(a, int'($urandom_range(1, 4)));
            do_read(a, int'($urandom_range(1, 5)), 1'b1);
        end

        // Reset while the target drives a 0 data bit
        dbuf[0] = 8'h5A;
        do_write(16'h0100, 1);
        i2c_start();
        put_byte(8'h20, ack);
        put_byte(8'h00, ack);
        put_byte(8'h00, ack);
        i2c_start();
        put_byte(8'h21, ack); check("rstmid_dev_ack", 16'(ack), 16'h0);
        msda = 1'b1; tick_q();
        scl  = 1'b1; tick_q();
        check("rstmid_driving_low", 16'(sda_bus), 16'h0);
        rstn = 1'b0;
        #1;
        check("rstmid_sda_released", 16'(sda_bus), 16'h1);
        check("rstmid_busy", 16'(busy), 16'h0);
        check("rstmid_nack_cnt", 16'(nack_cnt), 16'h0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick_q();
        for (int i = 0; i < DEPTH; i++) bank_m[i] = 8'h00;
        ptr_m  = 16'h0000;
        nack_m = 8'h00;
        do_read(16'h0000, 1, 1'b0);
        do_read(16'h0100, 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
